mapu_drv: RTL and testbench

Initiator/consumer for the Matrix APU (MAPU) block, the other end of its control and data-plane protocol. It holds two 3x3 operand matrices (A, B) loaded by a host, and streams them to the MAPU input port as six valid/ready row beats (A rows 0..2, then B rows 0..2). It then collects three result rows from the MAPU output port into a result buffer, and reports completion, overflow and timeout to the host.

---
 rtl/mapu_pkg.sv | 36 +++
 rtl/mapu_drv_row_buf.sv | 44 ++++
 rtl/mapu_drv.sv | 203 ++++++++++++++++++++
 tb/tb_mapu_drv.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mapu_pkg                                                     |
// | Description : Shared types and constants for the MAPU initiator/consumer.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mapu_pkg;

  // Rows per matrix and beats per operand matrix
  localparam int MAPU_ROWS = 3;

  // Operation code carried on m_op
  typedef enum logic {
    MAPU_OP_ADD  = 1'b0,
    MAPU_OP_MULT = 1'b1
  } mapu_op_e;

  // Driver FSM encoding
  typedef logic [1:0] mapu_state_t;
  localparam mapu_state_t ST_IDLE = 2'd0;
  localparam mapu_state_t ST_SEND = 2'd1;
  localparam mapu_state_t ST_RECV = 2'd2;
  localparam mapu_state_t ST_FIN  = 2'd3;

  // Row type at the default element width; modules with a different
  // DATA_WIDTH declare the same layout locally as a flat {r0,r1,r2} vector.
  localparam int MAPU_DW = 32;
  typedef logic [MAPU_DW-1:0] mapu_elem_t;
  typedef struct packed {
    mapu_elem_t r0;
    mapu_elem_t r1;
    mapu_elem_t r2;
  } mapu_row_t;

endpackage
`default_nettype wire

// File: rtl/mapu_drv_row_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mapu_drv_row_buf                                             |
// | Description : Three-entry row register file, one write port, one          |
// |               combinational read port; index 3 writes nothing, reads 0.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mapu_drv_row_buf
  import mapu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [1:0]              wr_idx,
  input  logic [3*DATA_WIDTH-1:0] wr_row,
  input  logic [1:0]              rd_idx,
  output logic [3*DATA_WIDTH-1:0] rd_row
);

  logic [3*DATA_WIDTH-1:0] mem [MAPU_ROWS];

  // Row storage; index 3 is not a real row so writes to it are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAPU_ROWS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_idx < 2'(MAPU_ROWS))) begin
      mem[wr_idx] <= wr_row;
    end
  end

  // Read port returns zero for the unused index
  always_comb begin
    rd_row = '0;
    if (rd_idx < 2'(MAPU_ROWS)) begin
      rd_row = mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mapu_drv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mapu_drv                                                     |
// | Description : MAPU initiator/consumer. Streams operand matrices A and B as |
// |               six row beats, collects three result rows, reports          |
// |               done / overflow / timeout to the host.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mapu_drv
  import mapu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_en,
  input  logic                  ld_sel,
  input  logic [1:0]            ld_row,
  input  logic [DATA_WIDTH-1:0] ld_r0,
  input  logic [DATA_WIDTH-1:0] ld_r1,
  input  logic [DATA_WIDTH-1:0] ld_r2,
  input  logic                  start,
  input  logic                  op,
  output logic                  busy,
  output logic                  done,
  output logic                  of_flag,
  output logic                  err,
  input  logic [1:0]            rd_row,
  output logic [DATA_WIDTH-1:0] rd_r0,
  output logic [DATA_WIDTH-1:0] rd_r1,
  output logic [DATA_WIDTH-1:0] rd_r2,
  output logic                  m_en,
  output logic                  m_op,
  input  logic                  m_of,
  output logic                  m_vld,
  output logic [DATA_WIDTH-1:0] m_r0,
  output logic [DATA_WIDTH-1:0] m_r1,
  output logic [DATA_WIDTH-1:0] m_r2,
  input  logic                  m_rdy,
  input  logic                  s_vld,
  input  logic [DATA_WIDTH-1:0] s_r0,
  input  logic [DATA_WIDTH-1:0] s_r1,
  input  logic [DATA_WIDTH-1:0] s_r2,
  output logic                  s_rdy
);

  // Abort fires on the edge that closes the (TIMEOUT_CYCLES-1)th quiet cycle,
  // so done/err appear TIMEOUT_CYCLES cycles after the last handshake.
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0]          BEAT_LAST = 3'd5;
  localparam logic [1:0]          RIDX_LAST = 2'(MAPU_ROWS - 1);

  mapu_state_t             state;
  logic [2:0]              beat;
  logic [1:0]              ridx;
  logic [TO_WIDTH-1:0]     to_cnt;

  logic                    in_send;
  logic                    in_recv;
  logic                    active;
  logic                    m_hs;
  logic                    s_hs;
  logic                    any_hs;
  logic                    timeout;
  logic                    ld_ok;
  logic [1:0]              a_idx;
  logic [1:0]              b_idx;
  logic [3*DATA_WIDTH-1:0] a_row;
  logic [3*DATA_WIDTH-1:0] b_row;
  logic [3*DATA_WIDTH-1:0] rd_data;

  assign in_send = (state == ST_SEND);
  assign in_recv = (state == ST_RECV);
  assign active  = in_send || in_recv;
  assign m_hs    = in_send && m_rdy;
  assign s_hs    = in_recv && s_vld;
  assign any_hs  = m_hs || s_hs;
  assign timeout = active && !any_hs && (to_cnt == TO_LAST);
  assign ld_ok   = (state == ST_IDLE) && ld_en;

  // Beats 0..2 come from A, 3..5 from B; the idle buffer reads index 3 (zero)
  assign a_idx = (beat < 3'd3) ? beat[1:0] : 2'd3;
  assign b_idx = (beat >= 3'd3) ? 2'(beat - 3'd3) : 2'd3;

  mapu_drv_row_buf #(.DATA_WIDTH(DATA_WIDTH)) u_a_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ld_ok && !ld_sel),
    .wr_idx (ld_row),
    .wr_row ({ld_r0, ld_r1, ld_r2}),
    .rd_idx (a_idx),
    .rd_row (a_row)
  );

  mapu_drv_row_buf #(.DATA_WIDTH(DATA_WIDTH)) u_b_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ld_ok && ld_sel),
    .wr_idx (ld_row),
    .wr_row ({ld_r0, ld_r1, ld_r2}),
    .rd_idx (b_idx),
    .rd_row (b_row)
  );

  mapu_drv_row_buf #(.DATA_WIDTH(DATA_WIDTH)) u_res_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (s_hs),
    .wr_idx (ridx),
    .wr_row ({s_r0, s_r1, s_r2}),
    .rd_idx (rd_row),
    .rd_row (rd_data)
  );

  assign {rd_r0, rd_r1, rd_r2} = rd_data;

  // Sequencer: operation FSM, beat/result indices, idle timer and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      beat    <= 3'd0;
      ridx    <= 2'd0;
      to_cnt  <= '0;
      m_op    <= 1'b0;
      of_flag <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SEND;
            beat    <= 3'd0;
            ridx    <= 2'd0;
            to_cnt  <= '0;
            m_op    <= op;
            of_flag <= 1'b0;
            err     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (m_rdy) begin
            to_cnt <= '0;
            if (beat == BEAT_LAST) begin
              state <= ST_RECV;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        ST_RECV: begin
          if (s_vld) begin
            to_cnt <= '0;
            if (ridx == RIDX_LAST) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              ridx <= ridx + 2'd1;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A quiet cycle either advances the idle timer or aborts straight to IDLE
      if (active && !any_hs) begin
        if (timeout) begin
          state <= ST_IDLE;
          err   <= 1'b1;
          done  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_WIDTH'(1);
        end
      end

      if (active && m_of) begin
        of_flag <= 1'b1;
      end
    end
  end

  // MAPU-facing controls and the outgoing row, all decoded from the state
  always_comb begin
    busy               = (state != ST_IDLE);
    m_en               = active;
    m_vld              = in_send;
    s_rdy              = in_recv;
    {m_r0, m_r1, m_r2} = '0;
    if (in_send) begin
      {m_r0, m_r1, m_r2} = (beat < 3'd3) ? a_row : b_row;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mapu_drv.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mapu_drv                                                  |
// | Description : Self-checking bench for mapu_drv with a transaction-level    |
// |               reference model and a MAPU responder.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mapu_drv;
  import mapu_pkg::*;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_en = 1'b0, ld_sel = 1'b0, start = 1'b0, op = 1'b0;
  logic [1:0]    ld_row = 2'd0, rd_row = 2'd0;
  logic [DW-1:0] ld_r0 = '0, ld_r1 = '0, ld_r2 = '0;
  logic          busy, done, of_flag, err, m_en, m_op, m_vld, s_rdy;
  logic [DW-1:0] rd_r0, rd_r1, rd_r2, m_r0, m_r1, m_r2;
  logic          m_of = 1'b0, m_rdy = 1'b0, s_vld = 1'b0;
  logic [DW-1:0] s_r0 = '0, s_r1 = '0, s_r2 = '0;

  mapu_drv #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_r0(ld_r0), .ld_r1(ld_r1), .ld_r2(ld_r2), .start(start), .op(op),
    .busy(busy), .done(done), .of_flag(of_flag), .err(err), .rd_row(rd_row),
    .rd_r0(rd_r0), .rd_r1(rd_r1), .rd_r2(rd_r2), .m_en(m_en), .m_op(m_op),
    .m_of(m_of), .m_vld(m_vld), .m_r0(m_r0), .m_r1(m_r1), .m_r2(m_r2),
    .m_rdy(m_rdy), .s_vld(s_vld), .s_r0(s_r0), .s_r1(s_r1), .s_r2(s_r2),
    .s_rdy(s_rdy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [DW-1:0] a_m [3][3];
  logic [DW-1:0] b_m [3][3];
  logic [DW-1:0] res_m [3][3];
  logic [DW-1:0] hs_log [$];
  int  cyc = 0, sent = 0, recv = 0, last_hs = 0;
  bit  act = 0, mdl_of = 0, mdl_err = 0, mdl_op = 0, injected = 0, rd_rand = 0;
  int  ops_done = 0, done_cyc = 0, hs_at_done = 0, acc_cyc = 0;
  int  rdy_mode = 0, vld_mode = 0, ret_mode = 0, of_mode = 0;
  int  n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a_m[i][j] = '0; b_m[i][j] = '0; res_m[i][j] = '0;
      end
    act = 0; sent = 0; recv = 0; mdl_of = 0; mdl_err = 0; mdl_op = 0;
  endtask

  // MAPU responder: drives the MAPU-side inputs for the coming cycle
  task automatic drive_mapu();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = pat[cyc % 4];
      2:       m_rdy = 1'($urandom % 2);
      default: m_rdy = (sent < 3);
    endcase
    s_vld = (vld_mode == 0) ? 1'b1 : 1'($urandom % 2);
    if (ret_mode == 0) begin
      s_r0 = a_m[(recv < 3) ? recv : 0][0];
      s_r1 = a_m[(recv < 3) ? recv : 0][1];
      s_r2 = a_m[(recv < 3) ? recv : 0][2];
    end else begin
      s_r0 = $urandom; s_r1 = $urandom; s_r2 = $urandom;
    end
    case (of_mode)
      1: begin
        m_of = 1'b0;
        if (act && sent == 6 && recv < 3 && !injected) begin
          m_of = 1'b1; injected = 1;
        end
      end
      2:       m_of = ($urandom % 8 == 0);
      default: m_of = 1'b0;
    endcase
    if (rd_rand) rd_row = 2'($urandom % 4);
  endtask

  // Per-cycle comparison against the transaction-level model, then model update
  task automatic check_cycle();
    bit e_busy, e_done, e_men, e_mvld, e_srdy, fin, abort;
    logic [DW-1:0] er0, er1, er2, xr0, xr1, xr2;
    e_busy = 0; e_done = 0; e_men = 0; e_mvld = 0; e_srdy = 0; fin = 0; abort = 0;
    er0 = '0; er1 = '0; er2 = '0;
    if (reset) begin
      clear_model();
    end else begin
      cyc++;
      if (act) begin
        if (sent == 6 && recv == 3) begin
          fin = 1; e_busy = 1; e_done = 1;
        end else if (cyc - last_hs == TO) begin
          abort = 1; e_done = 1; mdl_err = 1;
        end else begin
          e_busy = 1; e_men = 1;
          if (sent < 6) begin
            e_mvld = 1;
            if (sent < 3) begin er0 = a_m[sent][0]; er1 = a_m[sent][1]; er2 = a_m[sent][2]; end
            else begin er0 = b_m[sent-3][0]; er1 = b_m[sent-3][1]; er2 = b_m[sent-3][2]; end
          end else begin
            e_srdy = 1;
          end
        end
      end
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("m_en", m_en, e_men);
    chk("m_vld", m_vld, e_mvld);
    chk("s_rdy", s_rdy, e_srdy);
    chk("m_r0", m_r0, er0);
    chk("m_r1", m_r1, er1);
    chk("m_r2", m_r2, er2);
    chk("m_op", m_op, mdl_op);
    chk("of_flag", of_flag, mdl_of);
    chk("err", err, mdl_err);
    xr0 = '0; xr1 = '0; xr2 = '0;
    if (rd_row < 2'd3) begin xr0 = res_m[rd_row][0]; xr1 = res_m[rd_row][1]; xr2 = res_m[rd_row][2]; end
    chk("rd_r0", rd_r0, xr0);
    chk("rd_r1", rd_r1, xr1);
    chk("rd_r2", rd_r2, xr2);
    if (!reset) begin
      if (e_mvld && m_rdy) begin
        hs_log.push_back(m_r0); hs_log.push_back(m_r1); hs_log.push_back(m_r2);
        sent++; last_hs = cyc;
      end
      if (e_srdy && s_vld) begin
        res_m[recv][0] = s_r0; res_m[recv][1] = s_r1; res_m[recv][2] = s_r2;
        recv++; last_hs = cyc;
      end
      if (e_men && m_of) mdl_of = 1;
      if (fin || abort) begin
        act = 0; ops_done++; done_cyc = cyc; hs_at_done = last_hs;
      end
      if (!e_busy) begin
        if (ld_en && ld_row < 2'd3) begin
          if (ld_sel) begin b_m[ld_row][0] = ld_r0; b_m[ld_row][1] = ld_r1; b_m[ld_row][2] = ld_r2; end
          else        begin a_m[ld_row][0] = ld_r0; a_m[ld_row][1] = ld_r1; a_m[ld_row][2] = ld_r2; end
        end
        if (start) begin
          act = 1; sent = 0; recv = 0; last_hs = cyc; acc_cyc = cyc;
          mdl_of = 0; mdl_err = 0; mdl_op = op;
        end
      end
    end
  endtask

  initial begin : monitor
    clear_model();
    forever begin
      @(posedge clk); #1;
      drive_mapu();
      @(negedge clk);
      check_cycle();
    end
  end

  // ---------------- host-side stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic load(input bit sel, input logic [1:0] row,
                      input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    ld_en = 1; ld_sel = sel; ld_row = row; ld_r0 = v0; ld_r1 = v1; ld_r2 = v2;
    step(1);
    ld_en = 0;
  endtask

  task automatic run_op(input bit o);
    int prev, k;
    prev = ops_done; k = 0;
    start = 1; op = o;
    step(1);
    start = 0;
    while (ops_done == prev && k < 200) begin step(1); k++; end
    chk("op_completes", 32'(ops_done - prev), 32'd1);
  endtask

  int exp1 [18] = '{1,2,3,4,5,6,7,8,9,1,0,0,0,1,0,0,0,1};

  initial begin : main
    int k;
    reset = 1;
    step(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_en", m_en, 1'b0);
    chk("rst_rd_r0", rd_r0, '0);
    reset = 0;
    step(2);

    // Directed: A = 1..9, B = identity, MULT, full throughput, MAPU echoes A
    load(0, 2'd0, 1, 2, 3); load(0, 2'd1, 4, 5, 6); load(0, 2'd2, 7, 8, 9);
    load(1, 2'd0, 1, 0, 0); load(1, 2'd1, 0, 1, 0); load(1, 2'd2, 0, 0, 1);
    load(0, 2'd3, 32'hbad, 32'hbad, 32'hbad);
    rdy_mode = 0; vld_mode = 0; ret_mode = 0; of_mode = 0;
    hs_log.delete();
    run_op(MAPU_OP_MULT);
    chk("t1_latency", 32'(done_cyc - acc_cyc), 32'd10);
    chk("t1_beats", 32'(hs_log.size()), 32'd18);
    for (int i = 0; i < 18 && i < hs_log.size(); i++) chk("t1_beat_val", hs_log[i], 32'(exp1[i]));
    rd_row = 2'd1; #1;
    chk("t1_rd_r0", rd_r0, 32'd4); chk("t1_rd_r1", rd_r1, 32'd5); chk("t1_rd_r2", rd_r2, 32'd6);
    chk("t1_of", of_flag, 1'b0); chk("t1_err", err, 1'b0); chk("t1_m_op", m_op, 1'b1);
    step(1);

    // m_rdy pattern 1,0,0,1 during SEND, random results and s_vld
    rdy_mode = 1; vld_mode = 1; ret_mode = 1;
    hs_log.delete();
    run_op(MAPU_OP_ADD);
    chk("t2_beats", 32'(hs_log.size()), 32'd18);
    step(1);

    // One-cycle overflow during RECV
    rdy_mode = 0; vld_mode = 0; of_mode = 1; injected = 0;
    run_op(MAPU_OP_MULT);
    chk("t3_of_after_done", of_flag, 1'b1);
    of_mode = 0;
    step(1);

    // Load and start in the same cycle, then host traffic while busy
    hs_log.delete();
    ld_en = 1; ld_sel = 0; ld_row = 2'd0; ld_r0 = 9; ld_r1 = 9; ld_r2 = 9;
    start = 1; op = MAPU_OP_ADD;
    step(1);
    ld_en = 0; start = 0;
    chk("t4_of_cleared", of_flag, 1'b0);
    step(1);
    ld_en = 1; ld_sel = 0; ld_row = 2'd1; ld_r0 = 32'hdead; ld_r1 = 32'hdead; ld_r2 = 32'hdead;
    start = 1; op = MAPU_OP_MULT;
    step(1);
    ld_en = 0; start = 0;
    k = 0;
    while (act && k < 200) begin step(1); k++; end
    chk("t4_finished", 32'(act), 32'd0);
    chk("t4_first_r0", hs_log.size() > 0 ? hs_log[0] : '1, 32'd9);
    chk("t4_first_r2", hs_log.size() > 2 ? hs_log[2] : '1, 32'd9);
    chk("t4_busy_load_ignored", hs_log.size() > 3 ? hs_log[3] : '1, 32'd4);
    chk("t4_beats", 32'(hs_log.size()), 32'd18);
    step(2);

    // Timeout: m_rdy drops after beat 2
    rdy_mode = 3;
    hs_log.delete();
    run_op(MAPU_OP_MULT);
    chk("t5_timeout_gap", 32'(done_cyc - hs_at_done), 32'd16);
    chk("t5_beats", 32'(hs_log.size()), 32'd9);
    chk("t5_err", err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_m_vld", m_vld, 1'b0);
    chk("t5_done_pulse", done, 1'b0);
    step(1);

    // Randomized operations with random loads and MAPU behaviour
    rd_rand = 1;
    for (int n = 0; n < 10; n++) begin
      for (int l = 0; l < int'($urandom % 4); l++)
        load(1'($urandom % 2), 2'($urandom % 4), $urandom, $urandom, $urandom);
      rdy_mode = $urandom % 3; vld_mode = $urandom % 2; ret_mode = 1; of_mode = 2;
      run_op(1'($urandom % 2));
      step(int'($urandom % 3));
    end
    rd_rand = 0; of_mode = 0;

    // Reset while collecting results (after the first RECV beat)
    rdy_mode = 0; vld_mode = 0; ret_mode = 1;
    start = 1; op = MAPU_OP_MULT;
    step(1);
    start = 0;
    k = 0;
    while (!(act && recv == 1) && k < 50) begin step(1); k++; end
    chk("t6_reached_recv1", 32'(recv), 32'd1);
    reset = 1; #1;
    chk("t6_busy", busy, 1'b0); chk("t6_done", done, 1'b0); chk("t6_m_en", m_en, 1'b0);
    chk("t6_m_vld", m_vld, 1'b0); chk("t6_s_rdy", s_rdy, 1'b0); chk("t6_m_op", m_op, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rd_row = 2'(r); #1;
      chk("t6_rd_r0", rd_r0, '0); chk("t6_rd_r1", rd_r1, '0); chk("t6_rd_r2", rd_r2, '0);
      step(1);
    end
    reset = 0;
    step(2);
    run_op(MAPU_OP_ADD);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d, failures %0d)", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
